// File: rtl/n2tmux_rr.sv
// Registered N-channel by W-bit multiplexer with valid/ready handshakes.
// Selects by a fixed index (mode 0) or by round-robin arbitration (mode 1).
module n2tmux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load_en;
  logic                accept;
  logic                found;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic [SEL_W-1:0]    ptr;

  assign load_en  = !out_valid | out_ready;
  assign in_ready = (load_en && rst_n) ? grant : '0;
  assign accept   = |in_ready;

  // Round-robin searches from ptr+1 upward, wrapping, so ptr itself is last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && i == (int'(ptr) + off) % CHANNELS && in_valid[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      out_valid <= 1'b1;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
